traffic_state_sim: RTL
======================

Name: traffic_state_sim

Overview:
Parametrised multi-intersection traffic-state simulator, the next generation of the per-intersection state converter. It holds a saturating queue level for every lane of every intersection and applies one action per intersection on each accepted step. Steps are accepted through a valid/ready handshake and processed one intersection per cycle through a single shared update unit. It feeds packed states to the Q-learning agents during learning and passes measured traffic through in live mode.

Parameters:
N_INT, 2, number of intersections
N_LANE, 4, lanes per intersection
LVL_W, 3, bits per lane level; max level LMAX = 2^LVL_W-1
DRAIN_SHIFT, 1, right-shift applied to the served lane
ARR_INC, 1, saturating increment applied to unserved lanes; must satisfy 1 <= ARR_INC <= LMAX
ACT_W, 2, action width per intersection; must satisfy 2^ACT_W >= N_LANE

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
learning  in  1  1 = output simulated levels; 0 = output traffic_in
load_init  in  1  load init_state into all levels (IDLE only)
init_state  in  N_INT*N_LANE*LVL_W  initial levels, same packing as state_out
act_valid  in  1  action vector valid
act_ready  out  1  block can accept an action vector
action  in  N_INT*ACT_W  action of intersection i at [i*ACT_W +: ACT_W]
traffic_in  in  N_INT*N_LANE*LVL_W  measured traffic for live mode
state_out  out  N_INT*N_LANE*LVL_W  lane l of intersection i at [(i*N_LANE+l)*LVL_W +: LVL_W]
state_valid  out  1  one-cycle pulse: step complete
busy  out  1  FSM not in IDLE
sat_flag  out  N_INT  sticky: some lane of intersection i reached LMAX during a step

Behaviour:
- Reset, which overrides everything:
  - all levels = 0, FSM = IDLE, index = 0
  - state_valid = 0, sat_flag = 0, busy = 0, act_ready = 0 during the reset cycle
- FSM states are IDLE, UPDATE and DONE.
- act_ready = (FSM == IDLE) & ~rst & ~load_init. busy = (FSM != IDLE).
- IDLE:
  - If load_init = 1: levels <= init_state and sat_flag <= 0 on the next edge. load_init has priority over act_valid; no handshake occurs that cycle.
  - Else if act_valid & act_ready: register the action vector, index <= 0, go to UPDATE.
  - load_init outside IDLE is ignored.
- UPDATE, one intersection per cycle (i = index). For each lane l:
  - if action_reg[i] == l: L <= L >> DRAIN_SHIFT
  - else: L <= min(L + ARR_INC, LMAX), computed at LVL_W+1 bits with no wrap
  - If an action value is >= N_LANE, no lane is drained and all lanes increment.
  - sat_flag[i] <= sat_flag[i] | (any updated lane == LMAX).
  - If index == N_INT-1, go to DONE; otherwise index++.
- DONE: state_valid = 1 for exactly this cycle, then go to IDLE.
- Latency: handshake at edge T, intersection i updated at edge T+1+i, state_valid high in the cycle after edge T+N_INT. act_ready returns high in that same cycle's successor (IDLE).
- The action vector is registered at the handshake. Changes on the action input during UPDATE have no effect. act_valid while busy is not accepted.
- state_out is combinational: learning ? packed levels : traffic_in. Toggling learning mid-step affects only the output mux; level updates continue.
- Intersections not yet processed hold their values. state_out is only guaranteed coherent while state_valid = 1 or in IDLE.
- Reset asserted mid-UPDATE: the step is aborted, all levels are zeroed, and no state_valid pulse is issued.

Test Plan:
Use N_INT=2, N_LANE=4, LVL_W=3, DRAIN_SHIFT=1, ARR_INC=1 unless stated.
1. Reset, learning=1 -> state_out=0, sat_flag=0, state_valid=0; act_ready=1 in the first cycle after reset.
2. From zero, action A=0, B=3, handshake at T -> state_valid only in the cycle after edge T+2; A lanes 0..3 = 0,1,1,1 and B lanes 0..3 = 1,1,1,0.
3. load_init with all A lanes = 7 and B = 0, then A=0, B=0 -> A = 3,7,7,7; B = 0,1,1,1; sat_flag = 2'b01. A subsequent load_init clears sat_flag.
4. load_init A lane1 = 6, then three steps with A=1 -> A lane1 = 3, 1, 0 after successive steps; other A lanes saturate at 7 after 7 steps, not wrap.
5. learning=0 with traffic_in = 0xABC_123 pattern -> state_out equals traffic_in the same cycle; with learning=1 afterwards, state_out shows the internally updated levels.
6. Handshake, then act_valid held high and action changed during UPDATE -> exactly one step is applied, using the original vector. rst asserted at edge T+1 -> all levels 0, FSM IDLE, no state_valid pulse.

Source files
------------

// File: rtl/traffic_state_sim.sv
// Multi-intersection traffic-state simulator. Holds a saturating level per lane and
// applies one action vector per accepted step, one intersection per cycle.
module traffic_state_sim #(
  parameter int N_INT       = 2,
  parameter int N_LANE      = 4,
  parameter int LVL_W       = 3,
  parameter int DRAIN_SHIFT = 1,
  parameter int ARR_INC     = 1,
  parameter int ACT_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          learning,
  input  logic                          load_init,
  input  logic [N_INT*N_LANE*LVL_W-1:0] init_state,
  input  logic                          act_valid,
  output logic                          act_ready,
  input  logic [N_INT*ACT_W-1:0]        action,
  input  logic [N_INT*N_LANE*LVL_W-1:0] traffic_in,
  output logic [N_INT*N_LANE*LVL_W-1:0] state_out,
  output logic                          state_valid,
  output logic                          busy,
  output logic [N_INT-1:0]              sat_flag
);

  localparam int IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INT - 1);
  localparam logic [LVL_W-1:0] LMAX_L   = '1;
  localparam logic [LVL_W:0]   LMAX_X   = {1'b0, LMAX_L};
  localparam logic [LVL_W:0]   INC_X    = (LVL_W+1)'(ARR_INC);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t                          r_state, w_next;
  logic [IDX_W-1:0]                r_idx;
  logic [N_INT*ACT_W-1:0]          r_act;
  logic [N_INT*N_LANE*LVL_W-1:0]   r_lvl;
  logic [N_INT-1:0]                r_sat;
  logic                            w_accept;
  logic [ACT_W-1:0]                w_sel_act;
  logic [N_LANE-1:0][LVL_W-1:0]    w_cur, w_new;
  logic [N_LANE-1:0]               w_lane_sat;

  assign w_accept    = (r_state == S_IDLE) & act_valid & ~rst & ~load_init;
  assign act_ready   = (r_state == S_IDLE) & ~rst & ~load_init;
  assign busy        = (r_state != S_IDLE) & ~rst;
  assign state_valid = (r_state == S_DONE) & ~rst;
  assign sat_flag    = rst ? '0 : r_sat;
  assign state_out   = learning ? r_lvl : traffic_in;

  // Shared update unit: computes the next levels of intersection r_idx only.
  assign w_sel_act = r_act[int'(r_idx)*ACT_W +: ACT_W];

  for (genvar l = 0; l < N_LANE; l++) begin : g_lane
    logic [LVL_W:0] w_sum;
    assign w_cur[l]      = r_lvl[(int'(r_idx)*N_LANE + l)*LVL_W +: LVL_W];
    assign w_sum         = {1'b0, w_cur[l]} + INC_X;
    assign w_new[l]      = (w_sel_act == ACT_W'(l)) ? (w_cur[l] >> DRAIN_SHIFT)
                         : ((w_sum > LMAX_X) ? LMAX_L : w_sum[LVL_W-1:0]);
    assign w_lane_sat[l] = (w_new[l] == LMAX_L);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_UPDATE;
      S_UPDATE: if (r_idx == LAST_IDX) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= '0;
      r_sat <= '0;
      r_idx <= '0;
      r_act <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_init) begin
            r_lvl <= init_state;
            r_sat <= '0;
          end else if (w_accept) begin
            r_act <= action;
            r_idx <= '0;
          end
        end
        S_UPDATE: begin
          for (int l = 0; l < N_LANE; l++)
            r_lvl[(int'(r_idx)*N_LANE + l)*LVL_W +: LVL_W] <= w_new[l];
          r_sat[r_idx] <= r_sat[r_idx] | (|w_lane_sat);
          if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
